// File: rtl/ibex_dummy_instr_gen.sv
// Dummy-instruction generator for control-flow obfuscation.
// Counts real fetches accepted by ID and, once the count reaches a threshold (fixed or drawn
// from an internal Galois LFSR), substitutes a fake R-type ALU/MD op writing x0. A trigger can
// be followed by a burst of extra back-to-back dummies.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   en_i                    dummy insertion enable
//   fixed_mode_i            1: threshold = fixed_interval_i, 0: LFSR count field & interval_mask_i
//   interval_mask_i         AND-mask on the LFSR count field
//   fixed_interval_i        threshold in fixed mode
//   burst_len_i             extra back-to-back dummies per trigger
//   type_mask_i             per-type enable, bit index = type code (disabled types emit ADD)
//   seed_en_i, seed_i       seed strobe, value XORed into the LFSR state
//   fetch_valid_i           IF holds a real instruction
//   id_in_ready_i           ID accepts this cycle
//   insert_dummy_instr_o    select dummy in place of the fetched instruction
//   dummy_instr_data_o      dummy instruction word (combinational from the LFSR)
//   inserted_cnt_o          accepted dummies, saturating
module ibex_dummy_instr_gen #(
   parameter int unsigned             CNT_W     = 5,
   parameter int unsigned             LFSR_W    = 32,
   parameter logic [LFSR_W-1:0]       LFSR_SEED = 32'hACE1_2468,
   parameter logic [LFSR_W-1:0]       LFSR_TAPS = 32'h8020_0003,
   parameter int unsigned             BURST_W   = 2
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               en_i,
   input  logic               fixed_mode_i,
   input  logic [CNT_W-1:0]   interval_mask_i,
   input  logic [CNT_W-1:0]   fixed_interval_i,
   input  logic [BURST_W-1:0] burst_len_i,
   input  logic [7:0]         type_mask_i,
   input  logic               seed_en_i,
   input  logic [LFSR_W-1:0]  seed_i,
   input  logic               fetch_valid_i,
   input  logic               id_in_ready_i,
   output logic               insert_dummy_instr_o,
   output logic [31:0]        dummy_instr_data_o,
   output logic [15:0]        inserted_cnt_o
);

   localparam int unsigned OpALsb = CNT_W;
   localparam int unsigned OpBLsb = CNT_W + 5;
   localparam int unsigned TypeLsb = CNT_W + 10;

   typedef enum logic {StCount, StBurst} state_e;

   state_e             state_q, state_d;
   logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [BURST_W-1:0] burst_q, burst_d;
   logic [15:0]        ins_cnt_q, ins_cnt_d;

   logic [CNT_W-1:0]  thr;
   logic              insert;
   logic              accept;
   logic [LFSR_W-1:0] lfsr_step;
   logic [LFSR_W-1:0] lfsr_seeded;
   logic [2:0]        lfsr_type;
   logic [2:0]        type_eff;
   logic [6:0]        funct7;
   logic [2:0]        funct3;

   assign thr = fixed_mode_i ? fixed_interval_i : (lfsr_q[CNT_W-1:0] & interval_mask_i);

   // >= so that a lowered threshold fires at once instead of waiting for the counter to wrap.
   assign insert = en_i & ((state_q == StBurst) | (cnt_q >= thr));
   assign accept = insert & id_in_ready_i;

   assign lfsr_step   = {1'b0, lfsr_q[LFSR_W-1:1]} ^ (lfsr_q[0] ? LFSR_TAPS : '0);
   assign lfsr_seeded = lfsr_q ^ seed_i;

   always_comb begin
      state_d   = state_q;
      lfsr_d    = lfsr_q;
      cnt_d     = cnt_q;
      burst_d   = burst_q;
      ins_cnt_d = ins_cnt_q;

      // Seed write wins over a same-cycle step; an all-zero result would lock the LFSR up.
      if (seed_en_i) begin
         lfsr_d = (lfsr_seeded == '0) ? LFSR_SEED : lfsr_seeded;
      end else if (accept) begin
         lfsr_d = lfsr_step;
      end

      if (accept && (ins_cnt_q != 16'hFFFF)) begin
         ins_cnt_d = ins_cnt_q + 16'd1;
      end

      unique case (state_q)
         StCount: begin
            if (accept) begin
               cnt_d = '0;
               if (burst_len_i != '0) begin
                  burst_d = burst_len_i;
                  state_d = StBurst;
               end
            end else if (en_i && fetch_valid_i && id_in_ready_i) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         StBurst: begin
            if (!en_i) begin
               state_d = StCount;
               cnt_d   = '0;
               burst_d = '0;
            end else if (accept) begin
               burst_d = burst_q - BURST_W'(1);
               if (burst_q == BURST_W'(1)) begin
                  state_d = StCount;
               end
            end
         end
         default: state_d = StCount;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= StCount;
         lfsr_q    <= LFSR_SEED;
         cnt_q     <= '0;
         burst_q   <= '0;
         ins_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         lfsr_q    <= lfsr_d;
         cnt_q     <= cnt_d;
         burst_q   <= burst_d;
         ins_cnt_q <= ins_cnt_d;
      end
   end

   assign lfsr_type = lfsr_q[TypeLsb +: 3];
   assign type_eff  = type_mask_i[lfsr_type] ? lfsr_type : 3'd0;

   always_comb begin
      funct7 = 7'h00;
      funct3 = 3'd0;
      case (type_eff)
         3'd0: begin funct7 = 7'h00; funct3 = 3'd0; end  // ADD
         3'd1: begin funct7 = 7'h20; funct3 = 3'd0; end  // SUB
         3'd2: begin funct7 = 7'h01; funct3 = 3'd0; end  // MUL
         3'd3: begin funct7 = 7'h01; funct3 = 3'd1; end  // MULH
         3'd4: begin funct7 = 7'h01; funct3 = 3'd4; end  // DIV
         3'd5: begin funct7 = 7'h01; funct3 = 3'd6; end  // REM
         3'd6: begin funct7 = 7'h00; funct3 = 3'd7; end  // AND
         default: begin funct7 = 7'h00; funct3 = 3'd4; end  // XOR
      endcase
   end

   // rd = x0 keeps the dummy architecturally invisible.
   assign dummy_instr_data_o   = {funct7, lfsr_q[OpBLsb +: 5], lfsr_q[OpALsb +: 5], funct3,
                                  5'h00, 7'h33};
   assign insert_dummy_instr_o = insert;
   assign inserted_cnt_o       = ins_cnt_q;

endmodule

// File: tb/tb_ibex_dummy_instr_gen.sv
module tb_ibex_dummy_instr_gen;

   localparam logic [31:0] SEED = 32'hACE1_2468;
   localparam logic [31:0] TAPS = 32'h8020_0003;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, en, fixed, seed_en, fv, rdy;
   logic [4:0]  imask, fint;
   logic [1:0]  blen;
   logic [7:0]  tmask;
   logic [31:0] seed;
   logic        ins;
   logic [31:0] data;
   logic [15:0] icnt;

   ibex_dummy_instr_gen dut (
      .clk_i                (clk),
      .rst_i                (rst),
      .en_i                 (en),
      .fixed_mode_i         (fixed),
      .interval_mask_i      (imask),
      .fixed_interval_i     (fint),
      .burst_len_i          (blen),
      .type_mask_i          (tmask),
      .seed_en_i            (seed_en),
      .seed_i               (seed),
      .fetch_valid_i        (fv),
      .id_in_ready_i        (rdy),
      .insert_dummy_instr_o (ins),
      .dummy_instr_data_o   (data),
      .inserted_cnt_o       (icnt)
   );

   typedef struct packed {
      logic        ins;
      logic [31:0] data;
      logic [15:0] icnt;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model state
   logic [31:0] m_lfsr;
   logic [4:0]  m_cnt;
   logic [1:0]  m_burst;
   logic        m_in_burst;
   logic [15:0] m_icnt;
   logic        m_ins;

   logic        obs_ins;
   logic [31:0] obs_data;
   logic [15:0] obs_icnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] enc(input logic [31:0] l, input logic [7:0] tm);
      logic [2:0] t;
      logic [9:0] f;  // {funct7, funct3}
      t = l[17:15];
      if (!tm[t]) t = 3'd0;
      case (t)
         3'd0: f = {7'h00, 3'd0};
         3'd1: f = {7'h20, 3'd0};
         3'd2: f = {7'h01, 3'd0};
         3'd3: f = {7'h01, 3'd1};
         3'd4: f = {7'h01, 3'd4};
         3'd5: f = {7'h01, 3'd6};
         3'd6: f = {7'h00, 3'd7};
         default: f = {7'h00, 3'd4};
      endcase
      return {f[9:3], l[14:10], l[9:5], f[2:0], 5'h00, 7'h33};
   endfunction

   function automatic logic model_ins();
      logic [4:0] thr;
      thr = fixed ? fint : (m_lfsr[4:0] & imask);
      return en && (m_in_burst || (m_cnt >= thr));
   endfunction

   task automatic model_clock();
      logic        acc;
      logic [31:0] x;
      acc = m_ins && rdy;
      if (rst) begin
         m_lfsr = SEED; m_cnt = '0; m_burst = '0; m_in_burst = 1'b0; m_icnt = '0;
      end else begin
         x = m_lfsr ^ seed;
         if (seed_en) m_lfsr = (x == 32'h0) ? SEED : x;
         else if (acc) m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? TAPS : 32'h0);
         if (acc && (m_icnt != 16'hFFFF)) m_icnt = m_icnt + 16'd1;
         if (m_in_burst) begin
            if (!en) begin
               m_in_burst = 1'b0; m_cnt = '0; m_burst = '0;
            end else if (acc) begin
               if (m_burst == 2'd1) m_in_burst = 1'b0;
               m_burst = m_burst - 2'd1;
            end
         end else if (acc) begin
            m_cnt = '0;
            if (blen != 2'd0) begin
               m_burst = blen; m_in_burst = 1'b1;
            end
         end else if (en && fv && rdy) begin
            m_cnt = m_cnt + 5'd1;
         end
      end
   endtask

   // One clock: predict at the falling edge, compare, then advance the model at the rising edge.
   task automatic step(input bit do_chk);
      exp_t e, got;
      @(negedge clk);
      m_ins = model_ins();
      e.ins = m_ins; e.data = enc(m_lfsr, tmask); e.icnt = m_icnt;
      sb.push_back(e);
      obs_ins = ins; obs_data = data; obs_icnt = icnt;
      got = sb.pop_front();
      if (do_chk) begin
         chk("insert", {31'h0, obs_ins}, {31'h0, got.ins});
         chk("data", obs_data, got.data);
         chk("inserted_cnt", {16'h0, obs_icnt}, {16'h0, got.icnt});
      end
      @(posedge clk);
      model_clock();
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(1);
      rst = 1'b0;
   endtask

   initial begin
      int          n;
      logic [11:0] pat;
      logic [31:0] hold_data;
      logic [15:0] hold_icnt;

      rst = 1'b1; en = 1'b0; fixed = 1'b1; imask = 5'h1F; fint = 5'd3; blen = 2'd0;
      tmask = 8'hFF; seed_en = 1'b0; seed = 32'h0; fv = 1'b1; rdy = 1'b1;
      m_lfsr = SEED; m_cnt = '0; m_burst = '0; m_in_burst = 1'b0; m_icnt = '0; m_ins = 1'b0;
      step(0);
      step(0);
      rst = 1'b0;

      // Reset state
      step(1);
      chk("reset_insert", {31'h0, obs_ins}, 32'h0);
      chk("reset_icnt", {16'h0, obs_icnt}, 32'h0);
      chk("reset_data", obs_data, enc(SEED, 8'hFF));

      // T1: fixed interval 3, no burst
      do_reset();
      en = 1'b1; fixed = 1'b1; fint = 5'd3; blen = 2'd0;
      n = 0;
      repeat (20) begin
         step(1);
         if (obs_ins) n++;
      end
      chk("t1_insert_cycles", n, 5);
      chk("t1_icnt", {16'h0, icnt}, 32'd5);

      // T2: burst of 2 extra dummies
      do_reset();
      blen = 2'd2;
      for (int i = 0; i < 12; i++) begin
         step(1);
         pat[i] = obs_ins;
      end
      chk("t2_pattern", {20'h0, pat}, {20'h0, 12'b1110_0011_1000});

      // T3: random interval, ADD only
      do_reset();
      fixed = 1'b0; imask = 5'h1F; tmask = 8'h01; blen = 2'd0;
      for (int i = 0; i < 80; i++) begin
         fv = 1'($urandom);
         step(1);
         if (obs_ins) chk("t3_add_only", {10'h0, obs_data[31:25], obs_data[14:7], obs_data[6:0]},
                          {10'h0, 7'h00, 8'h00, 7'h33});
      end
      fv = 1'b1;

      // T4: seeding with the reset value collapses to zero and must reload the seed
      en = 1'b0;
      do_reset();
      seed_en = 1'b1; seed = SEED; tmask = 8'hFF;
      step(1);
      seed_en = 1'b0;
      en = 1'b1; fixed = 1'b1; fint = 5'd0;
      step(1);
      chk("t4_first_dummy", obs_data, enc(SEED, 8'hFF));
      chk("t4_insert", {31'h0, obs_ins}, 32'h1);

      // T5: ID stalls while a dummy is pending
      rdy = 1'b0;
      hold_data = enc(m_lfsr, tmask);
      hold_icnt = m_icnt;
      repeat (5) begin
         step(1);
         chk("t5_insert_held", {31'h0, obs_ins}, 32'h1);
         chk("t5_data_held", obs_data, hold_data);
         chk("t5_icnt_held", {16'h0, obs_icnt}, {16'h0, hold_icnt});
      end
      rdy = 1'b1;

      // T6: reset mid-burst, then enable drop mid-burst
      do_reset();
      fint = 5'd0; blen = 2'd3;
      step(1);
      step(1);
      rst = 1'b1; fint = 5'd2;
      step(1);
      rst = 1'b0;
      step(1);
      chk("t6_rst_insert", {31'h0, obs_ins}, 32'h0);
      chk("t6_rst_data", obs_data, enc(SEED, tmask));
      fint = 5'd0;
      step(1);
      step(1);
      en = 1'b0;
      step(1);
      en = 1'b1; fint = 5'd2;
      step(1);
      chk("t6_en_drop_insert", {31'h0, obs_ins}, 32'h0);

      // Randomised traffic against the model
      for (int i = 0; i < 500; i++) begin
         rst     = ($urandom_range(63) == 0);
         en      = ($urandom_range(7) != 0);
         fixed   = 1'($urandom);
         imask   = 5'($urandom);
         fint    = 5'($urandom_range(6));
         blen    = 2'($urandom);
         tmask   = 8'($urandom);
         seed_en = ($urandom_range(15) == 0);
         seed    = ($urandom_range(3) == 0) ? m_lfsr : $urandom;
         fv      = ($urandom_range(3) != 0);
         rdy     = ($urandom_range(3) != 0);
         step(1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
